regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL use the constant CPU_REG_WIDTH, default 32, as the data width of each register and port.
REQ-002 SHALL use the constant CPU_REGNO_WIDTH, default 5, as the register-number width; 2^CPU_REGNO_WIDTH = 32 registers.
REQ-003 SHALL provide the ports below, one per line: name, direction, width, meaning.
- clk  input  1  clock; all state updates on the rising edge.
- nrst  input  1  reset; asynchronous, active-low.
- i_rd_no  input  CPU_REGNO_WIDTH  write register number from the writeback stage; 0 = no write.
- i_rd_val  input  CPU_REG_WIDTH  write data from the writeback stage.
- i_rs_no  input  CPU_REGNO_WIDTH  read port A register number from decode.
- i_rt_no  input  CPU_REGNO_WIDTH  read port B register number from decode.
- o_rs_val  output  CPU_REG_WIDTH  read port A data, combinational.
- o_rt_val  output  CPU_REG_WIDTH  read port B data, combinational.
- o_busy  output  1  clear sweep in progress; the CU SHALL treat this as a core stall.

Function
REQ-004 SHALL keep the storage array unreset (RAM-inferable) and initialise it with a clear sweep FSM with states CLEAR and RUN.
REQ-005 In CLEAR, SHALL write zero to the register selected by a sweep counter on each rising edge, starting at 1 and incrementing by 1.
REQ-006 SHALL move from CLEAR to RUN on the edge that clears register 31, so CLEAR lasts exactly 31 clock edges after nrst deasserts.
REQ-007 SHALL drive o_busy high in CLEAR and low in RUN; o_busy is a registered output and falls together with the CLEAR-to-RUN transition.
REQ-008 In CLEAR, SHALL ignore i_rd_no/i_rd_val and force o_rs_val and o_rt_val to 0.
REQ-009 In RUN, SHALL write i_rd_val into register i_rd_no on the rising edge when i_rd_no != 0; a write with i_rd_no == 0 is a no-op.
REQ-010 SHALL return 0 for register 0 on both read ports regardless of any prior write.
REQ-011 In RUN, SHALL return the stored value of i_rs_no on o_rs_val and of i_rt_no on o_rt_val, combinationally, with zero cycles of latency.
REQ-012 SHALL allow both read ports to select the same register in the same cycle, each returning the identical value.
REQ-013 SHALL make a write visible to reads in the cycle after its write edge, subject to REQ-018.
REQ-014 SHALL hold the sweep counter at 31 and never wrap once in RUN; RUN is left only through reset.

Reset
REQ-015 On nrst low, SHALL immediately enter CLEAR, set the sweep counter to 1, drive o_busy to 1, and force o_rs_val and o_rt_val to 0.
REQ-016 If nrst asserts mid-sweep or in RUN, SHALL abort any activity and restart the full 31-cycle sweep after release.
REQ-017 SHALL NOT write the storage array while nrst is low.

Configuration
REQ-018 With macro CPU_REGFILE_BYPASS_EN defined, in RUN, SHALL drive a read port with i_rd_val in the same cycle when its register number equals i_rd_no != 0 (write-to-read bypass, applied to each port independently).
REQ-019 Without CPU_REGFILE_BYPASS_EN, SHALL return the old stored value in that same cycle, with the new value visible on the next cycle.

Verification
REQ-020 SHALL be covered by the following directed scenarios, one per line: stimulus -> required response.
- Release nrst, then hold i_rd_no=5, i_rd_val=0xDEADBEEF -> o_busy=1 for exactly 31 edges; reads return 0 throughout; r5 stays 0 after the sweep.
- In RUN, write r7=0x12345678, then next cycle set i_rs_no=7 and i_rt_no=7 -> both ports read 0x12345678.
- Write i_rd_no=0 with i_rd_val=0xFFFFFFFF, then read r0 -> 0.
- Write r3=0xA5A5A5A5 while reading r3 in the same cycle -> with CPU_REGFILE_BYPASS_EN the read is 0xA5A5A5A5; without it the read is the old value (0 after the sweep) and 0xA5A5A5A5 next cycle.
- Assert nrst at sweep cycle 10, release it, then write r31=1 -> o_busy=1 for a full 31 further edges; r31 then reads 1.
- Write all of r1..r31 with value = register number, then read all pairs -> each port returns its register number; r0 reads 0.

Source files
------------

// File: rtl/regfile.sv
// regfile: 2-read / 1-write CPU register file with a hardware clear sweep.
//
// The storage array carries no reset so it can map onto RAM. After nrst is
// released, a sweep writes zero into r1..r31, one register per clock, while
// o_busy stalls the core. r0 is never stored; it always reads as zero.
//
// Build option: define CPU_REGFILE_BYPASS_EN so that a read of the register
// being written in the same cycle returns the incoming write data. Without
// it, that read returns the old contents, and the new value appears one
// cycle later.
//
// state | meaning
// ------+-----------------------------------------------------------------
// CLEAR | sweep zeroing r1..r31; writes ignored, reads forced to 0, busy=1
// RUN   | normal operation; sweep counter parked at 31, busy=0

module regfile #(
  parameter int CPU_REG_WIDTH   = 32,
  parameter int CPU_REGNO_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [CPU_REGNO_WIDTH-1:0] i_rd_no,
  input  logic [CPU_REG_WIDTH-1:0]   i_rd_val,
  input  logic [CPU_REGNO_WIDTH-1:0] i_rs_no,
  input  logic [CPU_REGNO_WIDTH-1:0] i_rt_no,
  output logic [CPU_REG_WIDTH-1:0]   o_rs_val,
  output logic [CPU_REG_WIDTH-1:0]   o_rt_val,
  output logic                       o_busy
);

  localparam int REG_COUNT = 1 << CPU_REGNO_WIDTH;
  localparam logic [CPU_REGNO_WIDTH-1:0] REGNO_ZERO = '0;
  localparam logic [CPU_REGNO_WIDTH-1:0] REGNO_ONE  = 1;
  localparam logic [CPU_REGNO_WIDTH-1:0] REGNO_LAST = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                       state;
  logic [CPU_REGNO_WIDTH-1:0]   sweep_no;
  logic                         busy_q;

  logic [CPU_REG_WIDTH-1:0]     mem [0:REG_COUNT-1];

  logic                         wr_en;
  logic [CPU_REGNO_WIDTH-1:0]   wr_no;
  logic [CPU_REG_WIDTH-1:0]     wr_val;

  logic [CPU_REG_WIDTH-1:0]     rs_val;
  logic [CPU_REG_WIDTH-1:0]     rt_val;

  // Sweep FSM: walk r1..r31 after reset, then park in RUN until the next reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= CLEAR;
      sweep_no <= REGNO_ONE;
      busy_q   <= 1'b1;
    end else begin
      if (state == CLEAR) begin
        if (sweep_no == REGNO_LAST) begin
          // Leave CLEAR on the edge that zeroes the top register; the
          // counter stays at 31 from here on.
          state  <= RUN;
          busy_q <= 1'b0;
        end else begin
          sweep_no <= sweep_no + REGNO_ONE;
        end
      end else begin
        state    <= RUN;
        sweep_no <= sweep_no;
        busy_q   <= 1'b0;
      end
    end
  end

  // Select the write source: the sweep while clearing, writeback while running.
  // nrst gates the enable so that nothing lands in the array during reset.
  always_comb begin
    wr_en  = 1'b0;
    wr_no  = REGNO_ZERO;
    wr_val = '0;
    if (nrst) begin
      if (state == CLEAR) begin
        wr_en  = 1'b1;
        wr_no  = sweep_no;
        wr_val = '0;
      end else if (i_rd_no != REGNO_ZERO) begin
        wr_en  = 1'b1;
        wr_no  = i_rd_no;
        wr_val = i_rd_val;
      end
    end
  end

  // Storage array write port; no reset so that it stays RAM-inferable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_no] <= wr_val;
    end
  end

  // Read ports: zero during CLEAR and for r0. In RUN, optionally forward
  // same-cycle write data when the port hits the register being written.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (state == RUN) begin
      if (i_rs_no != REGNO_ZERO) begin
        rs_val = mem[i_rs_no];
`ifdef CPU_REGFILE_BYPASS_EN
        if (i_rs_no == i_rd_no) begin
          rs_val = i_rd_val;
        end
`endif
      end
      if (i_rt_no != REGNO_ZERO) begin
        rt_val = mem[i_rt_no];
`ifdef CPU_REGFILE_BYPASS_EN
        if (i_rt_no == i_rd_no) begin
          rt_val = i_rd_val;
        end
`endif
      end
    end
  end

  assign o_rs_val = rs_val;
  assign o_rt_val = rt_val;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scoreboard bench for regfile.
// The stimulus process drives one vector per clock and queues the expected
// port values; a monitor pops one entry on each falling edge and compares.

module tb_regfile;

  localparam int W = 32;
  localparam int N = 5;

  logic          clk;
  logic          nrst;
  logic [N-1:0]  i_rd_no;
  logic [W-1:0]  i_rd_val;
  logic [N-1:0]  i_rs_no;
  logic [N-1:0]  i_rt_no;
  logic [W-1:0]  o_rs_val;
  logic [W-1:0]  o_rt_val;
  logic          o_busy;

  typedef struct {
    string        name;
    logic         busy;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   bypass;

  regfile #(.CPU_REG_WIDTH(W), .CPU_REGNO_WIDTH(N)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .i_rd_no  (i_rd_no),
    .i_rd_val (i_rd_val),
    .i_rs_no  (i_rs_no),
    .i_rt_no  (i_rt_no),
    .o_rs_val (o_rs_val),
    .o_rt_val (o_rt_val),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are settled at the falling edge; pop one expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (o_busy !== e.busy || o_rs_val !== e.rs || o_rt_val !== e.rt) begin
        miscompares++;
        $display("FAIL %s: got busy=%0b rs=%h rt=%h, required busy=%0b rs=%h rt=%h",
                 e.name, o_busy, o_rs_val, o_rt_val, e.busy, e.rs, e.rt);
      end
    end
  end

  // Apply one vector just after a rising edge and queue its expected outputs.
  task automatic step(input logic rst_v, input logic [N-1:0] rd, input logic [W-1:0] val,
                      input logic [N-1:0] rs, input logic [N-1:0] rt,
                      input logic ebusy, input logic [W-1:0] ers, input logic [W-1:0] ert,
                      input string name);
    exp_t e;
    nrst     = rst_v;
    i_rd_no  = rd;
    i_rd_val = val;
    i_rs_no  = rs;
    i_rt_no  = rt;
    e.name = name;
    e.busy = ebusy;
    e.rs   = ers;
    e.rt   = ert;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef CPU_REGFILE_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    nrst     = 1'b0;
    i_rd_no  = '0;
    i_rd_val = '0;
    i_rs_no  = '0;
    i_rt_no  = '0;
    @(posedge clk);
    #1;

    // Reset state: busy, reads forced to 0 even with a write request present.
    step(1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b1, 32'h0, 32'h0, "reset_hold");
    step(1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 32'h0, 32'h0, "reset_hold2");

    // Sweep: exactly 31 busy cycles, writes to r5 ignored, reads 0.
    for (int k = 1; k <= 31; k++)
      step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b1, 32'h0, 32'h0, "sweep_busy");
    step(1'b1, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 32'h0, 32'h0, "sweep_done_r5_zero");

    // Write r7 then read it on both ports.
    step(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "wr_r7");
    step(1'b1, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 32'h12345678, 32'h12345678, "rd_r7_both");

    // Write to r0 is a no-op.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "wr_r0");
    step(1'b1, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 32'h0, 32'h12345678, "rd_r0");

    // Same-cycle write/read of r3, then bypass on one port only (r2).
    step(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 1'b0,
         bypass ? 32'hA5A5A5A5 : 32'h0, bypass ? 32'hA5A5A5A5 : 32'h0, "wr_rd_same_r3");
    step(1'b1, 5'd2, 32'h00000055, 5'd3, 5'd2, 1'b0,
         32'hA5A5A5A5, bypass ? 32'h00000055 : 32'h0, "rd_r3_wr_r2");
    step(1'b1, 5'd0, 32'h0, 5'd2, 5'd3, 1'b0, 32'h00000055, 32'hA5A5A5A5, "rd_r2_r3");

    // Reset asserted in RUN: outputs forced to 0 immediately.
    step(1'b0, 5'd7, 32'h77777777, 5'd7, 5'd3, 1'b1, 32'h0, 32'h0, "reset_in_run");

    // Release, sweep 10 cycles, reset again mid-sweep, then full 31-cycle sweep.
    for (int k = 1; k <= 10; k++)
      step(1'b1, 5'd0, 32'h0, 5'd7, 5'd3, 1'b1, 32'h0, 32'h0, "sweep_pre_abort");
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd3, 1'b1, 32'h0, 32'h0, "reset_mid_sweep");
    for (int k = 1; k <= 31; k++)
      step(1'b1, 5'd31, 32'h1, 5'd31, 5'd7, 1'b1, 32'h0, 32'h0, "sweep_restart");
    step(1'b1, 5'd31, 32'h1, 5'd31, 5'd7, 1'b0,
         bypass ? 32'h1 : 32'h0, 32'h0, "wr_r31_after_restart");
    step(1'b1, 5'd0, 32'h0, 5'd31, 5'd3, 1'b0, 32'h1, 32'h0, "rd_r31_r3_cleared");

    // Fill r1..r31 with their own numbers, then read every pair.
    for (int k = 1; k <= 31; k++)
      step(1'b1, N'(k), W'(k), 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "fill");
    for (int k = 0; k <= 31; k++)
      step(1'b1, 5'd0, 32'h0, N'(k), N'(31 - k), 1'b0, W'(k), W'(31 - k), "rd_pairs");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
